// File: rtl/cnn_bn_relu_1x1.sv
// Folded batch-norm (per-channel scale/shift) plus optional ReLU for the 1x1 conv output stream.
// Parameters are loaded once after reset, then every frame is processed with a 3-cycle latency.
module cnn_bn_relu_1x1 #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned FRAC_BITS       = 8,
    parameter int unsigned IMAGE_WIDTH     = 16,
    parameter int unsigned IMAGE_HEIGHT    = 16,
    parameter int unsigned CHANNEL_NUM_OUT = 512,
    parameter int unsigned RELU_EN         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_param_in,
    input  logic [DATA_WIDTH-1:0] param_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  param_ready,
    output logic                  frame_done,
    output logic                  err_drop
);

    localparam int unsigned IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned PARAM_NUM  = 2 * CHANNEL_NUM_OUT;
    localparam int unsigned PIX_W  = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned CH_W   = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int unsigned P_W    = $clog2(PARAM_NUM);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = PROD_W + 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_OUT - 1);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(PARAM_NUM - 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t state, state_next;

    logic [P_W-1:0]   p;
    logic [PIX_W-1:0] pix_cnt;
    logic [CH_W-1:0]  ch_cnt;
    logic             param_we;
    logic             pix_acc;
    logic             pix_drop;

    logic [DATA_WIDTH-1:0] scale_mem [CHANNEL_NUM_OUT];
    logic [DATA_WIDTH-1:0] shift_mem [CHANNEL_NUM_OUT];

    logic                         s1_valid, s1_last;
    logic signed [DATA_WIDTH-1:0] s1_pxl, s1_scale, s1_shift;
    logic                         s2_valid, s2_last;
    logic signed [PROD_W-1:0]     s2_prod;
    logic signed [DATA_WIDTH-1:0] s2_shift;
    logic signed [SUM_W-1:0]      sum;
    logic [DATA_WIDTH-1:0]        res;

    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD;
        else       state <= state_next;
    end

    // Next state plus the per-cycle accept/drop strobes.
    always_comb begin
        state_next = state;
        param_we   = 1'b0;
        pix_acc    = 1'b0;
        pix_drop   = 1'b0;
        case (state)
            S_LOAD: begin
                param_we = valid_param_in;
                pix_drop = valid_in;
                if (valid_param_in && (p == P_LAST)) state_next = S_RUN;
            end
            S_RUN: begin
                pix_acc = valid_in;
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                       p <= '0;
        else if (param_we && p != P_LAST) p <= p + P_W'(1);
    end

    // Parameter RAM write and stage-1 synchronous read at the current channel.
    always_ff @(posedge clk) begin
        if (param_we) begin
            if (p[0]) shift_mem[CH_W'(p >> 1)] <= param_in;
            else      scale_mem[CH_W'(p >> 1)] <= param_in;
        end
        if (pix_acc) begin
            s1_pxl   <= pxl_in;
            s1_scale <= scale_mem[ch_cnt];
            s1_shift <= shift_mem[ch_cnt];
            s1_last  <= (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt  <= '0;
            ch_cnt   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= pix_acc;
            if (pix_acc) begin
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt <= '0;
                    ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_W'(1);
                end else begin
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s2_valid <= 1'b0;
        else       s2_valid <= s1_valid;
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            s2_prod  <= PROD_W'(s1_pxl) * PROD_W'(s1_scale);
            s2_shift <= s1_shift;
            s2_last  <= s1_last;
        end
    end

    // Floor shift, bias add, saturate, then optional clamp of negatives.
    always_comb begin
        sum = SUM_W'(s2_prod >>> FRAC_BITS) + SUM_W'(s2_shift);
        res = sum[DATA_WIDTH-1:0];
        if ((RELU_EN != 0) && sum[SUM_W-1]) res = '0;
        else if (sum > SAT_MAX)             res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (sum < SAT_MIN)             res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out     <= '0;
            valid_out   <= 1'b0;
            frame_done  <= 1'b0;
            param_ready <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            valid_out   <= s2_valid;
            frame_done  <= s2_valid && s2_last;
            param_ready <= (state_next == S_RUN);
            if (s2_valid) pxl_out  <= res;
            if (pix_drop) err_drop <= 1'b1;
        end
    end

endmodule
